data_sram_resp: RTL and testbench
=================================

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 Parameter ADDR_W, default 10, word-index width; storage depth is 2**ADDR_W words of 32 bits.
REQ-002 Parameter INIT_VAL, default 32'h0, value written to every word by the post-reset clear sequence.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 resetn  input  1  reset; asynchronous assert, active-low.
REQ-005 data_sram_en  input  1  request valid this cycle.
REQ-006 data_sram_wen  input  4  byte-lane write enables; bit i writes wdata[8i+7:8i]; 4'b0000 with en=1 means read.
REQ-007 data_sram_addr  input  32  byte address; addr[ADDR_W+1:2] is the word index; addr[1:0] is ignored.
REQ-008 data_sram_wdata  input  32  store data, already lane-aligned by the requester.
REQ-009 data_sram_rdata  output  32  read data for the request accepted in the previous cycle.
REQ-010 init_done  output  1  high once the clear sequence completes; requests before that are not serviced.
REQ-011 oor_err  output  1  sticky flag; set by any accepted request whose addr[31:ADDR_W+2] is nonzero.

Function
REQ-012 A request is accepted when data_sram_en=1 and init_done=1; requests while init_done=0 are dropped with no storage or rdata effect.
REQ-013 The FSM SHALL have two states, CLEAR and SERVE; reset enters CLEAR.
REQ-014 In CLEAR, a counter SHALL write INIT_VAL to word 0, 1, ... one word per cycle; the transition to SERVE happens on the cycle after word 2**ADDR_W-1 is written; CLEAR lasts exactly 2**ADDR_W cycles.
REQ-015 init_done=1 exactly when the state is SERVE; there is no path from SERVE back to CLEAR except reset.
REQ-016 An accepted read (wen=0) SHALL drive data_sram_rdata with the full addressed word on the next cycle; read latency is exactly 1 cycle.
REQ-017 data_sram_rdata SHALL hold its last value in any cycle that follows a non-read cycle (idle, write, dropped, or CLEAR).
REQ-018 An accepted write SHALL update only the lanes whose wen bit is 1, at the clock edge ending the request cycle; the other lanes keep their value.
REQ-019 A write with wen nonzero SHALL NOT change data_sram_rdata.
REQ-020 A read issued the cycle after a write to the same word SHALL return the merged post-write word; no stale data is returned.
REQ-021 Out-of-range accepted requests (addr[31:ADDR_W+2]!=0) SHALL set oor_err. A read returns 32'h0 next cycle. A write is discarded and does not alias onto in-range words.
REQ-022 Back-to-back accepted requests every cycle SHALL be serviced without stalls; the block has no ready or backpressure output.
REQ-023 Single port: at most one request per cycle; no request/clear collision exists because CLEAR drops requests.

Reset
REQ-024 While resetn=0: state=CLEAR, clear counter=0, data_sram_rdata=32'h0, init_done=0, oor_err=0, independent of clk.
REQ-025 Reset asserted mid-CLEAR or mid-SERVE SHALL abort the operation and restart the full clear sequence after deassertion; storage contents are undefined until that clear completes.
REQ-026 The oor_err flag SHALL clear only on reset.

Structure
REQ-027 Shared package or header mycpu.h holds the FSM state encodings (DSR_CLEAR, DSR_SERVE) and the default ADDR_W; no bus-width macros are added.
REQ-028 One natural sub-module: data_sram_bank, a single 32-bit-wide array with a 4-bit byte write mask and a registered read output. The FSM, clear counter and range check stay in data_sram_resp.
REQ-029 Target size is 120-400 RTL lines; no vendor RAM primitives are used.

Verification
REQ-030 Release reset with ADDR_W=4 and count cycles: init_done rises exactly 16 cycles later; then read word 5 -> rdata=INIT_VAL next cycle.
REQ-031 Write addr 0x14, wen=4'b1111, wdata=0xDEADBEEF; next cycle read 0x14 -> rdata=0xDEADBEEF; next cycle read 0x17 -> rdata=0xDEADBEEF (addr[1:0] ignored).
REQ-032 Starting from word 0x12345678, write wen=4'b0101, wdata=0xAABBCCDD; then read -> rdata=0x12BB56DD.
REQ-033 Continuous reads of words 1,2,3 on consecutive cycles -> rdata returns those values on the following three cycles; an idle cycle then holds the last value.
REQ-034 Write to 0x0001_0000 with ADDR_W=4 -> oor_err=1, word 0 unchanged; a read of that address -> rdata=0; oor_err stays 1 until reset.
REQ-035 Assert resetn=0 asynchronously mid-clear at cycle 7 -> outputs go to reset values immediately; after release, the full 16-cycle clear reruns before init_done=1.

Source files
------------

// File: rtl/data_sram_resp_pkg.sv
// +------------------------------------------------------------------+
// | data_sram_resp_pkg : FSM state encodings and default word width   |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package data_sram_resp_pkg;

  localparam int DSR_ADDR_W = 10;

  typedef enum logic [0:0] {
    DSR_CLEAR = 1'b0,
    DSR_SERVE = 1'b1
  } dsr_state_e;

endpackage

`default_nettype wire

// File: rtl/data_sram_bank.sv
// +------------------------------------------------------------------+
// | data_sram_bank : 32-bit word array, byte write mask, registered   |
// | read port.  rev 1.0                                               |
// +------------------------------------------------------------------+
`default_nettype none

module data_sram_bank
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_W = DSR_ADDR_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        wmask,
  input  logic [31:0]       wdata,
  input  logic              rd_en,
  input  logic              rd_zero,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // Storage carries no reset; the owner clears it explicitly after reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wmask[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata <= 32'h0;
    end else if (rd_en) begin
      rdata <= rd_zero ? 32'h0 : mem[addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_sram_resp.sv
// +------------------------------------------------------------------+
// | data_sram_resp : data SRAM responder with post-reset clear and    |
// | sticky out-of-range flag.  rev 1.0                                |
// +------------------------------------------------------------------+
`default_nettype none

module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          ADDR_W   = DSR_ADDR_W,
  parameter logic [31:0] INIT_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        init_done,
  output logic        oor_err
);

  dsr_state_e        state;
  dsr_state_e        state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic              accept;
  logic              oor;
  logic [ADDR_W-1:0] bank_addr;
  logic [3:0]        bank_wmask;
  logic [31:0]       bank_wdata;
  logic              bank_rd_en;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^data_sram_addr[1:0];

  assign init_done = (state == DSR_SERVE);
  assign accept    = data_sram_en && init_done;
  assign oor       = |data_sram_addr[31:ADDR_W+2];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= DSR_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DSR_CLEAR: if (clr_cnt == '1) state_nxt = DSR_SERVE;
      DSR_SERVE: state_nxt = DSR_SERVE;
      default:   state_nxt = DSR_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clr_cnt <= '0;
    end else if (state == DSR_CLEAR) begin
      clr_cnt <= clr_cnt + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      oor_err <= 1'b0;
    end else if (accept && oor) begin
      oor_err <= 1'b1;
    end
  end

  // The clear sequence owns the single bank port; requests are dropped then.
  always_comb begin
    bank_addr  = data_sram_addr[ADDR_W+1:2];
    bank_wmask = 4'b0000;
    bank_wdata = data_sram_wdata;
    bank_rd_en = 1'b0;
    if (state == DSR_CLEAR) begin
      bank_addr  = clr_cnt;
      bank_wmask = 4'b1111;
      bank_wdata = INIT_VAL;
    end else if (accept) begin
      bank_wmask = oor ? 4'b0000 : data_sram_wen;
      bank_rd_en = (data_sram_wen == 4'b0000);
    end
  end

  data_sram_bank #(
    .ADDR_W(ADDR_W)
  ) u_bank (
    .clk     (clk),
    .resetn  (resetn),
    .addr    (bank_addr),
    .wmask   (bank_wmask),
    .wdata   (bank_wdata),
    .rd_en   (bank_rd_en),
    .rd_zero (oor),
    .rdata   (data_sram_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_data_sram_resp.sv
// +------------------------------------------------------------------+
// | tb_data_sram_resp : directed self-checking bench, ADDR_W=4        |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_data_sram_resp;

  localparam int          AW   = 4;
  localparam logic [31:0] INIT = 32'hCAFE_0001;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  wen = 4'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        init_done;
  logic        oor_err;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  data_sram_resp #(
    .ADDR_W   (AW),
    .INIT_VAL (INIT)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .init_done       (init_done),
    .oor_err         (oor_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request cycle: drive, let the edge take it, sample 1 time unit later.
  task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] d);
    en = e; wen = w; addr = a; wdata = d;
    @(posedge clk); #1;
    en = 1'b0; wen = 4'b0;
  endtask

  initial begin
    #12;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_oor_err", oor_err, 1'b0);

    @(posedge clk); #1;
    resetn = 1'b1;
    n = 0;
    while (!init_done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("clear_cycles", n, 16);

    cyc(1, 4'b0000, 32'h14, 0);
    chk("read_w5_init", rdata, INIT);

    cyc(1, 4'b1111, 32'h14, 32'hDEAD_BEEF);
    chk("write_keeps_rdata", rdata, INIT);
    cyc(1, 4'b0000, 32'h14, 0);
    chk("raw_read_0x14", rdata, 32'hDEAD_BEEF);
    cyc(1, 4'b0000, 32'h17, 0);
    chk("read_0x17", rdata, 32'hDEAD_BEEF);

    cyc(1, 4'b1111, 32'h18, 32'h1234_5678);
    cyc(1, 4'b0101, 32'h18, 32'hAABB_CCDD);
    chk("partial_write_keeps_rdata", rdata, 32'hDEAD_BEEF);
    cyc(1, 4'b0000, 32'h18, 0);
    chk("byte_merge", rdata, 32'h12BB_56DD);

    cyc(1, 4'b1111, 32'h04, 32'h1111_1111);
    cyc(1, 4'b1111, 32'h08, 32'h2222_2222);
    cyc(1, 4'b1111, 32'h0C, 32'h3333_3333);
    cyc(1, 4'b0000, 32'h04, 0);
    chk("b2b_read_w1", rdata, 32'h1111_1111);
    cyc(1, 4'b0000, 32'h08, 0);
    chk("b2b_read_w2", rdata, 32'h2222_2222);
    cyc(1, 4'b0000, 32'h0C, 0);
    chk("b2b_read_w3", rdata, 32'h3333_3333);
    cyc(0, 4'b0000, 32'h04, 0);
    chk("idle_hold", rdata, 32'h3333_3333);
    chk("oor_clear_before", oor_err, 1'b0);

    cyc(1, 4'b1111, 32'h0001_0000, 32'hFFFF_FFFF);
    chk("oor_set", oor_err, 1'b1);
    cyc(1, 4'b0000, 32'h00, 0);
    chk("oor_no_alias_w0", rdata, INIT);
    cyc(1, 4'b0000, 32'h0001_0000, 0);
    chk("oor_read_zero", rdata, 32'h0);
    cyc(0, 4'b0000, 0, 0);
    cyc(0, 4'b0000, 0, 0);
    chk("oor_sticky", oor_err, 1'b1);

    // Asynchronous reset in SERVE with live outputs.
    cyc(1, 4'b0000, 32'h04, 0);
    chk("pre_reset_rdata", rdata, 32'h1111_1111);
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    chk("async_rst_rdata", rdata, 32'h0);
    chk("async_rst_oor", oor_err, 1'b0);
    chk("async_rst_init_done", init_done, 1'b0);

    // Restart clear, abort it at cycle 7, then run a full clear.
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (7) begin @(posedge clk); #1; end
    #2;
    resetn = 1'b0;
    #1;
    chk("midclear_init_done", init_done, 1'b0);
    chk("midclear_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    n = 0;
    repeat (10) begin @(posedge clk); #1; n++; end
    // A write to an already-cleared word during CLEAR must be dropped.
    en = 1'b1; wen = 4'b1111; addr = 32'h0; wdata = 32'h7777_7777;
    @(posedge clk); #1; n++;
    en = 1'b0; wen = 4'b0;
    while (!init_done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reclear_cycles", n, 16);

    cyc(1, 4'b0000, 32'h14, 0);
    chk("reclear_w5", rdata, INIT);
    cyc(1, 4'b0000, 32'h00, 0);
    chk("dropped_clear_write", rdata, INIT);
    chk("oor_after_reset", oor_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
